// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, MEM-stage branch flushes,
// variable-latency dmem freeze with timeout. Optional statistics counters under HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_use_rt,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_wreg,
  input  logic       MEM_Branch,
  input  logic       MEM_zero,
  input  logic       MEM_MemRead,
  input  logic       MEM_MemWrite,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       pc_we,
  output logic       pc_src_br,
  output logic       IFID_we,
  output logic       IFID_flush,
  output logic       IDEX_we,
  output logic       IDEX_flush,
  output logic       EXMEM_we,
  output logic       EXMEM_flush,
  output logic       MEMWB_bubble,
  output logic       mem_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  localparam int WCNT = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT-1:0] CNT_MAX = WCNT'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, HALT = 2'd2} state_e;

  state_e          state_r;
  logic [WCNT-1:0] cnt_r;
  logic            mem_err_r;

  logic memop_s;
  logic br_taken_s;
  logic load_use_s;
  logic run_br_s;
  logic run_lu_s;

  assign memop_s    = MEM_MemRead | MEM_MemWrite;
  assign br_taken_s = MEM_Branch & MEM_zero;
  // r0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use_s = EX_MemRead && (EX_wreg != 5'd0) &&
                      ((EX_wreg == ID_rs) || (ID_use_rt && (EX_wreg == ID_rt)));
  assign run_br_s   = (state_r == RUN) && !memop_s && br_taken_s;
  assign run_lu_s   = (state_r == RUN) && !memop_s && !br_taken_s && load_use_s;
  assign mem_err    = mem_err_r;

  // Pipeline control decode from current state and hazard inputs
  always_comb begin
    dmem_req     = 1'b0;
    pc_we        = 1'b0;
    pc_src_br    = 1'b0;
    IFID_we      = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_we      = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_we     = 1'b0;
    EXMEM_flush  = 1'b0;
    MEMWB_bubble = 1'b0;
    if (rst) begin
      {IFID_flush, IDEX_flush, EXMEM_flush, MEMWB_bubble} = 4'b1111;
    end else begin
      case (state_r)
        RUN: begin
          if (memop_s) begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b1111;
            end else begin
              MEMWB_bubble = 1'b1;
            end
          end else if (br_taken_s) begin
            {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b1111;
            {pc_src_br, IFID_flush, IDEX_flush, EXMEM_flush} = 4'b1111;
          end else if (load_use_s) begin
            {IDEX_we, IDEX_flush, EXMEM_we} = 3'b111;
          end else begin
            {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b1111;
          end
        end
        MWAIT: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            {pc_we, IFID_we, IDEX_we, EXMEM_we} = 4'b1111;
          end else begin
            MEMWB_bubble = 1'b1;
          end
        end
        HALT: begin
          MEMWB_bubble = 1'b1;
        end
        default: begin
          MEMWB_bubble = 1'b1;
        end
      endcase
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      cnt_r     <= {WCNT{1'b0}};
      mem_err_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (memop_s && !dmem_ready) begin
            cnt_r   <= WCNT'(1);
            state_r <= MWAIT;
          end
        end
        MWAIT: begin
          if (dmem_ready) begin
            cnt_r   <= {WCNT{1'b0}};
            state_r <= RUN;
          end else if (cnt_r == CNT_MAX) begin
            mem_err_r <= 1'b1;
            state_r   <= HALT;
          end else begin
            cnt_r <= cnt_r + WCNT'(1);
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= {WCNT{1'b0}};
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};

  // Saturating event counters for load-use stalls, branch flushes and memory waits
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= {CNT_W{1'b0}};
      flush_cnt   <= {CNT_W{1'b0}};
      memwait_cnt <= {CNT_W{1'b0}};
    end else begin
      if (run_lu_s && (stall_cnt != STAT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (run_br_s && (flush_cnt != STAT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      if ((state_r == MWAIT) && (memwait_cnt != STAT_MAX)) memwait_cnt <= memwait_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
